// File: rtl/tri_pkg.sv
// Shared definitions for the triangle-wave scheduler: FSM state encoding,
// default datapath widths and the command record offered by each requester.
package tri_pkg;

    // FSM state encoding; all four codes of the 2-bit state are in use.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RISE = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_FALL = 2'd3;

    // Default widths: waveform/peak, hold counter, period counter.
    localparam int unsigned W_DEF  = 9;
    localparam int unsigned HW_DEF = 8;
    localparam int unsigned NW_DEF = 4;

    // One waveform command at the default widths.
    typedef struct packed {
        logic [W_DEF-1:0]  peak;
        logic [HW_DEF-1:0] hold;
        logic [NW_DEF-1:0] num;
    } tri_cmd_t;

endpackage

// File: rtl/tri_rr_arb.sv
// Two-way round-robin grant: the favoured requester wins when it is valid,
// otherwise the other one. The grant value is meaningless when o_any is low.
module tri_rr_arb (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_prio,
    output logic o_grant,
    output logic o_any
);

    // Pick the favoured requester if it asks, else fall back to the other one.
    always_comb begin
        o_any = i_valid0 | i_valid1;
        if (i_prio) begin
            if (i_valid1) begin
                o_grant = 1'b1;
            end else begin
                o_grant = 1'b0;
            end
        end else begin
            if (i_valid0) begin
                o_grant = 1'b0;
            end else begin
                o_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_sched.sv
// Two-requester scheduler for the shared triangle-wave datapath.
// Accepts one command at a time in IDLE, then sequences RISE/HOLD/FALL for
// the requested number of periods and pulses done on the following IDLE cycle.
module tri_sched
    import tri_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned HW = HW_DEF,
    parameter int unsigned NW = NW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [W-1:0]  req0_peak,
    input  logic [W-1:0]  req1_peak,
    input  logic [HW-1:0] req0_hold,
    input  logic [HW-1:0] req1_hold,
    input  logic [NW-1:0] req0_num,
    input  logic [NW-1:0] req1_num,
    output logic [W-1:0]  d_out,
    output logic          busy,
    output logic          owner,
    output logic          done
);

    localparam logic [W-1:0]  L_D_ZERO  = {W{1'b0}};
    localparam logic [W-1:0]  L_D_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] L_C_ZERO  = {HW{1'b0}};
    localparam logic [HW-1:0] L_C_ONE   = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] L_N_ZERO  = {NW{1'b0}};
    localparam logic [NW-1:0] L_N_ONE   = {{(NW-1){1'b0}}, 1'b1};

    // Architectural state
    logic [1:0]    r_state;
    logic [W-1:0]  r_d_out;
    logic [W-1:0]  r_pk;
    logic [HW-1:0] r_con;
    logic [HW-1:0] r_hd;
    logic [NW-1:0] r_left;
    logic          r_owner;
    logic          r_prio;
    logic          r_done;
    logic          r_busy;

    // Next-state values
    logic [1:0]    w_state_nxt;
    logic [W-1:0]  w_d_nxt;
    logic [W-1:0]  w_pk_nxt;
    logic [HW-1:0] w_con_nxt;
    logic [HW-1:0] w_hd_nxt;
    logic [NW-1:0] w_left_nxt;
    logic          w_owner_nxt;
    logic          w_prio_nxt;
    logic          w_done_nxt;

    // Arbitration and selected command
    logic          w_grant;
    logic          w_any;
    logic          w_idle;
    logic          w_accept;
    logic [W-1:0]  w_sel_peak;
    logic [W-1:0]  w_sel_peak_cl;
    logic [HW-1:0] w_sel_hold;
    logic [NW-1:0] w_sel_num;

    // Datapath arithmetic
    logic [W-1:0]  w_d_inc;
    logic [W-1:0]  w_d_dec;
    logic [HW-1:0] w_con_inc;
    logic [NW-1:0] w_left_dec;

    tri_rr_arb u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_prio   (r_prio),
        .o_grant  (w_grant),
        .o_any    (w_any)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle & w_any;
    assign req0_ready = w_accept & ~w_grant;
    assign req1_ready = w_accept &  w_grant;

    assign w_d_inc    = r_d_out + L_D_ONE;
    assign w_d_dec    = r_d_out - L_D_ONE;
    assign w_con_inc  = r_con + L_C_ONE;
    assign w_left_dec = r_left - L_N_ONE;

    // Mux the granted requester's command; a zero peak is raised to one so
    // every non-empty command still produces a visible triangle.
    always_comb begin
        if (w_grant) begin
            w_sel_peak = req1_peak;
            w_sel_hold = req1_hold;
            w_sel_num  = req1_num;
        end else begin
            w_sel_peak = req0_peak;
            w_sel_hold = req0_hold;
            w_sel_num  = req0_num;
        end
        if (w_sel_peak == L_D_ZERO) begin
            w_sel_peak_cl = L_D_ONE;
        end else begin
            w_sel_peak_cl = w_sel_peak;
        end
    end

    // Scheduler FSM: accept in IDLE, then ramp up, plateau, ramp down per period.
    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d_out;
        w_pk_nxt    = r_pk;
        w_con_nxt   = r_con;
        w_hd_nxt    = r_hd;
        w_left_nxt  = r_left;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_pk_nxt    = w_sel_peak_cl;
                    w_hd_nxt    = w_sel_hold;
                    w_left_nxt  = w_sel_num;
                    w_owner_nxt = w_grant;
                    w_prio_nxt  = ~w_grant;
                    w_d_nxt     = L_D_ZERO;
                    if (w_sel_num == L_N_ZERO) begin
                        // Empty command: complete immediately, no waveform.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RISE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RISE: begin
                w_d_nxt = w_d_inc;
                if (w_d_inc == r_pk) begin
                    w_state_nxt = ST_HOLD;
                    w_con_nxt   = L_C_ZERO;
                end else begin
                    w_state_nxt = ST_RISE;
                end
            end
            ST_HOLD: begin
                // Plateau lasts hd+1 cycles: con counts 0..hd.
                if (r_con == r_hd) begin
                    w_state_nxt = ST_FALL;
                    w_con_nxt   = L_C_ZERO;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_con_nxt   = w_con_inc;
                end
            end
            ST_FALL: begin
                w_d_nxt = w_d_dec;
                if (w_d_dec == L_D_ZERO) begin
                    if (r_left > L_N_ONE) begin
                        // More periods to run: restart the ramp without idling.
                        w_left_nxt  = w_left_dec;
                        w_state_nxt = ST_RISE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_FALL;
                end
            end
            default: begin
                // Unreachable encoding: park quietly in IDLE.
                w_state_nxt = ST_IDLE;
                w_d_nxt     = L_D_ZERO;
                w_con_nxt   = L_C_ZERO;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any command in flight.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_d_out <= L_D_ZERO;
            r_pk    <= L_D_ZERO;
            r_con   <= L_C_ZERO;
            r_hd    <= L_C_ZERO;
            r_left  <= L_N_ZERO;
            r_owner <= 1'b0;
            r_prio  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d_out <= w_d_nxt;
            r_pk    <= w_pk_nxt;
            r_con   <= w_con_nxt;
            r_hd    <= w_hd_nxt;
            r_left  <= w_left_nxt;
            r_owner <= w_owner_nxt;
            r_prio  <= w_prio_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign d_out = r_d_out;
    assign busy  = r_busy;
    assign owner = r_owner;
    assign done  = r_done;

endmodule

// File: tb/tb_tri_sched.sv
// Self-checking bench for tri_sched: directed scenarios plus randomized
// traffic, compared against a per-cycle expected-output queue built from the
// waveform rules (ramp 0..pk-1, plateau pk for hold+1 cycles, ramp pk..1).
module tb_tri_sched;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic       req0_ready;
    logic       req1_ready;
    logic [8:0] req0_peak = 9'd0;
    logic [8:0] req1_peak = 9'd0;
    logic [7:0] req0_hold = 8'd0;
    logic [7:0] req1_hold = 8'd0;
    logic [3:0] req0_num  = 4'd0;
    logic [3:0] req1_num  = 4'd0;
    logic [8:0] d_out;
    logic       busy;
    logic       owner;
    logic       done;

    tri_sched dut (
        .clk        (clk),
        .res        (res),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_peak  (req0_peak),
        .req1_peak  (req1_peak),
        .req0_hold  (req0_hold),
        .req1_hold  (req1_hold),
        .req0_num   (req0_num),
        .req1_num   (req1_num),
        .d_out      (d_out),
        .busy       (busy),
        .owner      (owner),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] d;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    bit   m_prio  = 1'b0;
    bit   m_owner = 1'b0;
    bit   pend0   = 1'b0;
    bit   pend1   = 1'b0;
    bit   rnd_mode = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc  = 0;

    task automatic chk(input string tag, input int got, input int exp_v);
        n_chk++;
        if (got == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp_v, $time);
    endtask

    task automatic push_one(input int dv, input bit b, input bit dn);
        exp_t e;
        e.d    = 9'(dv);
        e.busy = b;
        e.done = dn;
        q.push_back(e);
    endtask

    // Expected per-cycle outputs following an accept.
    task automatic push_cmd(input int peak, input int hold, input int num);
        int pk;
        pk = (peak == 0) ? 1 : peak;
        for (int p = 0; p < num; p++) begin
            for (int i = 0; i < pk; i++) push_one(i, 1'b1, 1'b0);
            for (int i = 0; i <= hold; i++) push_one(pk, 1'b1, 1'b0);
            for (int i = pk; i >= 1; i--) push_one(i, 1'b1, 1'b0);
        end
        push_one(0, 1'b0, 1'b1);
    endtask

    task automatic rnd_stim();
        if (!pend0) begin
            if ($urandom_range(0, 3) == 0) begin
                pend0 = 1'b1;
                req0_peak = 9'($urandom_range(0, 12));
                req0_hold = 8'($urandom_range(0, 4));
                req0_num  = 4'($urandom_range(0, 3));
            end else begin
                req0_peak = 9'($urandom);
                req0_hold = 8'($urandom);
                req0_num  = 4'($urandom);
            end
        end
        if (!pend1) begin
            if ($urandom_range(0, 3) == 0) begin
                pend1 = 1'b1;
                req1_peak = 9'($urandom_range(0, 12));
                req1_hold = 8'($urandom_range(0, 4));
                req1_num  = 4'($urandom_range(0, 3));
            end else begin
                req1_peak = 9'($urandom);
                req1_hold = 8'($urandom);
                req1_num  = 4'($urandom);
            end
        end
    endtask

    // One clock cycle: check registered outputs, drive valids, check readys,
    // advance the model on an accept.
    task automatic step();
        exp_t cur;
        bit   acc;
        bit   g;
        @(posedge clk);
        #1;
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{9'd0, 1'b0, 1'b0};
        chk("d_out", int'(d_out), int'(cur.d));
        chk("busy",  int'(busy),  int'(cur.busy));
        chk("done",  int'(done),  int'(cur.done));
        chk("owner", int'(owner), int'(m_owner));
        if (rnd_mode) rnd_stim();
        req0_valid = pend0;
        req1_valid = pend1;
        #1;
        acc = !cur.busy && (pend0 || pend1);
        if (m_prio ? pend1 : pend0) g = m_prio;
        else g = !m_prio;
        chk("ready0", int'(req0_ready), int'(acc && !g));
        chk("ready1", int'(req1_ready), int'(acc && g));
        if (acc) begin
            if (!g) begin
                push_cmd(int'(req0_peak), int'(req0_hold), int'(req0_num));
                pend0 = 1'b0;
            end else begin
                push_cmd(int'(req1_peak), int'(req1_hold), int'(req1_num));
                pend1 = 1'b0;
            end
            m_owner = g;
            m_prio  = !g;
            n_acc++;
        end
    endtask

    task automatic run_until_idle(input int maxc);
        int n;
        n = 0;
        while ((pend0 || pend1 || q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain", q.size() + int'(pend0) + int'(pend1), 0);
    endtask

    task automatic set0(input int pk, input int hd, input int nm);
        req0_peak = 9'(pk); req0_hold = 8'(hd); req0_num = 4'(nm); pend0 = 1'b1;
    endtask

    task automatic set1(input int pk, input int hd, input int nm);
        req1_peak = 9'(pk); req1_hold = 8'(hd); req1_num = 4'(nm); pend1 = 1'b1;
    endtask

    initial begin
        int acc_goal;
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_d_out",  int'(d_out), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_owner",  int'(owner), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_ready1", int'(req1_ready), 0);
        res = 1'b0;

        // Basic triangle
        set0(3, 2, 1);
        run_until_idle(100);
        step();

        // Simultaneous pairs, twice, plus a third pair
        for (int k = 0; k < 3; k++) begin
            set0(2, 0, 1);
            set1(2, 0, 1);
            run_until_idle(100);
        end

        // Multi-period
        set1(4, 1, 3);
        run_until_idle(100);

        // Edge commands: zero peak, zero periods, back to back
        set0(0, 0, 1);
        run_until_idle(50);
        set1(7, 3, 0);
        run_until_idle(50);
        set0(5, 0, 0);
        set1(0, 2, 2);
        run_until_idle(50);

        // Maximum values
        set1(511, 255, 1);
        run_until_idle(3000);

        // Reset in the middle of a plateau
        set0(3, 5, 1);
        step();
        for (int i = 0; i < 5; i++) step();
        res = 1'b1;
        #1;
        chk("mid_rst_d_out", int'(d_out), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_done",  int'(done), 0);
        chk("mid_rst_owner", int'(owner), 0);
        q.delete();
        m_prio  = 1'b0;
        m_owner = 1'b0;
        pend0   = 1'b0;
        pend1   = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_done_hold", int'(done), 0);
        res = 1'b0;
        set0(2, 0, 1);
        set1(2, 0, 1);
        run_until_idle(100);

        // Randomized traffic
        rnd_mode = 1'b1;
        acc_goal = n_acc + 40;
        for (int c = 0; c < 6000 && n_acc < acc_goal; c++) step();
        rnd_mode = 1'b0;
        run_until_idle(3000);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tri_sched.md
# tri_sched

Two-requester scheduler for the shared triangle-wave datapath. Each requester submits a waveform command (peak, plateau length, period count) over a valid/ready handshake; the block arbitrates round-robin, then sequences the up-count / hold / down-count datapath for the requested number of periods. It drives the shared 9-bit waveform bus and reports ownership and completion.

## Interface
- `W`, default 9: `d_out` / peak width.
- `HW`, default 8: hold-counter width.
- `NW`, default 4: period-count width.

- `clk`  in  1  sole clock, rising edge.
- `res`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  command offered.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle when valid&&ready.
- `req0_peak`, `req1_peak`  in  W  triangle peak value.
- `req0_hold`, `req1_hold`  in  HW  plateau length minus one, in cycles.
- `req0_num`, `req1_num`  in  NW  number of periods.
- `d_out`  out  W  waveform sample.
- `busy`  out  1  high while a command executes (RISE/HOLD/FALL).
- `owner`  out  1  index of the requester whose command is executing or last executed.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, RISE, HOLD, FALL. Registers: `d_out`, `con` (HW), `left` (NW), `pk` (W), `hd` (HW), `owner`, `prio` (1 bit, favoured requester).
- IDLE: grant = the `prio` requester if it is valid, else the other if it is valid. `reqN_ready` = (state==IDLE) && grant==N. This is combinational and depends on valid. No ready is asserted outside IDLE.
- On accept:
  - Latch peak/hold/num into `pk`/`hd`/`left`.
  - `owner` <= grant; `prio` <= ~grant.
  - `d_out` stays 0.
  - Peak 0 is clamped to 1.
  - num==0: no waveform; return to IDLE and pulse `done` next cycle.
  - Otherwise go to RISE.
- RISE: `d_out` <= `d_out`+1. When `d_out`+1 == `pk`, go to HOLD with `con` <= 0.
- HOLD: `d_out` is held. If `con` == `hd`, go to FALL with `con` <= 0; else `con`+1. HOLD lasts `hd`+1 cycles.
- FALL: `d_out` <= `d_out`-1. When `d_out`-1 == 0:
  - If `left` > 1: decrement `left`, go to RISE.
  - Else: go to IDLE, `done` <= 1.
- Period length = 2·pk + hd + 1 cycles. `d_out` never exceeds `pk` and never wraps.
- Unused state encoding: recover to IDLE with `d_out`=0, `con`=0, no `done`.
- Input changes while busy are ignored; parameters are captured only at accept.

## Timing
- Reset values: `d_out`=0, `busy`=0, `owner`=0, `done`=0, state=IDLE, `prio`=0, `con`=0, `left`=0. Both readys are 0 unless a valid is present in IDLE.
- Accept cycle T: `busy`=1 and first increment are visible from T+1. `d_out`=1 at T+2.
- `done` is high exactly one cycle: the first IDLE cycle after the final FALL step, with `d_out`=0 in that cycle.
- A new command can be accepted in the same cycle `done` is high. The first sample of the next command follows with no bubble beyond that IDLE cycle.
- Simultaneous valids: the `prio` requester wins. The loser's valid must stay high; it is served next.
- Reset asserted mid-command: all registers return to reset values immediately. The command is discarded and no `done` is produced.

## Structure
- Package `tri_pkg`:
  - State encoding localparams: IDLE=0, RISE=1, HOLD=2, FALL=3.
  - Default widths W/HW/NW.
  - Command struct/field widths.
- Sub-module `tri_rr_arb`: 2-way round-robin grant logic (valid0, valid1, prio → grant, any). The top holds the FSM, counters and `prio` update.

## Test plan
- Reset, then req0 {peak=3, hold=2, num=1}: `d_out` 1,2,3,3,3,3,2,1,0. `done` is high with the final 0, 9 cycles after the first increment. `owner`=0.
- req0 and req1 valid together from reset, both {peak=2, hold=0, num=1}: req0 served first, then req1 accepted in req0's `done` cycle. `owner` goes 0 then 1. A third simultaneous pair is served req0 first again.
- req1 {peak=4, hold=1, num=3}: three identical periods of 10 cycles. `done` fires once after 30 cycles. `busy` stays continuously high.
- Edge commands: {peak=0, num=1} produces 0,1,1,0 (hold=0, clamped to peak=1). {num=0} produces `done` one cycle after accept with `d_out` staying 0.
- Max values {peak=511, hold=255, num=1}: `d_out` reaches 511, holds 256 cycles, returns to 0 with no wrap. Total 1278 cycles.
- Assert `res` during HOLD: `d_out`=0 and `busy`=0 immediately, no `done` pulse. `prio` resets to favour req0.
